odd_parity_tx: RTL and testbench

- Serial frame transmitter directly downstream of the 8-bit odd-parity generator.
- Accepts a byte plus its externally generated odd-parity bit through a valid/ready handshake.
- Serializes UART-style, LSB first: start(0), 8 data bits, parity, stop(1).
- Drives a single line that idles high.

---
 rtl/odd_parity_tx.sv | 173 +++++++++++++++++
 tb/tb_odd_parity_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/odd_parity_tx.sv
// UART-style odd-parity frame transmitter: start(0), DATA_W data bits LSB first, parity, stop(1).
// Define ODD_PARITY_CHECK_EN to flag a mismatch between parity_in and the parity recomputed from data_in.
module odd_parity_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              parity_err
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                accept;
  logic                baudWrap;

  assign ready_out = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = valid_in && ready_out;
  assign baudWrap  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_START;
          shift_d  = data_in;
          parity_d = parity_in;
          baud_d   = '0;
          bit_d    = '0;
        end
      end
      S_START: begin
        if (baudWrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baudWrap) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_PARITY;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (baudWrap) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baudWrap) begin
          baud_d  = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // tx is decoded from the next state so the line register already holds the new bit on its first cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;

`ifdef ODD_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;

  // Flag is re-evaluated on every accept and otherwise holds; it never alters the transmitted parity.
  always_comb begin
    parity_err_d = parity_err_q;
    if (accept) begin
      parity_err_d = ((~^data_in) != parity_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_odd_parity_tx.sv
// Scoreboard bench for odd_parity_tx: stimulus pushes expected frames, a line monitor decodes tx and compares.
module tb_odd_parity_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 44;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       parity_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_out, tx, busy, done, parity_err;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int doneCount = 0;
  logic [10:0] expQ[$];
  int startTimes[$];

  bit          inFrame = 1'b0;
  bit          doneWait = 1'b0;
  bit          stable = 1'b1;
  int          mCyc = 0;
  logic        prevTx = 1'b1;
  logic [10:0] rxBits = '0;
  logic [10:0] expFrame = '0;

  odd_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_in(parity_in),
    .valid_in(valid_in), .ready_out(ready_out), .tx(tx), .busy(busy),
    .done(done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame in transmission order: bit0 start, bits 8:1 data LSB first, bit9 parity, bit10 stop.
  function automatic logic [10:0] frameOf(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic p, input bit hold);
    checkOutput("accept_ready", ready_out, 1);
    data_in   = d;
    parity_in = p;
    valid_in  = 1'b1;
    expQ.push_back(frameOf(d, p));
    @(posedge clk);
    #1;
    if (!hold) valid_in = 1'b0;
  endtask

  task automatic waitDone(output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        n = i;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout actual=no_done required=done_within_100");
    end
  endtask

  // Line monitor: decodes each frame from tx, checks bit stability, then the done cycle that follows.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inFrame  = 1'b0;
        doneWait = 1'b0;
        prevTx   = 1'b1;
      end else begin
        if (done) doneCount++;
        if (doneWait) begin
          doneWait = 1'b0;
          checkOutput("done_pulse", done, 1);
          checkOutput("done_ready", ready_out, 1);
        end else if (done) begin
          checkOutput("spurious_done", done, 0);
        end
        if (inFrame) begin
          if (mCyc % CPB == 0) rxBits[mCyc / CPB] = tx;
          else if (tx !== rxBits[mCyc / CPB]) stable = 1'b0;
          mCyc++;
          if (mCyc == FRAME_CYC) begin
            inFrame  = 1'b0;
            doneWait = 1'b1;
            checkOutput("bit_stable", stable, 1);
            if (expQ.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpected_frame actual=0x%0h required=no_frame", rxBits);
            end else begin
              expFrame = expQ.pop_front();
              checkOutput("frame_bits", rxBits, expFrame);
            end
          end
        end else if (prevTx === 1'b1 && tx === 1'b0) begin
          inFrame   = 1'b1;
          mCyc      = 1;
          stable    = 1'b1;
          rxBits    = '0;
          rxBits[0] = tx;
          startTimes.push_back(cycle);
        end
        prevTx = tx;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int s0;
    int d0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_ready", ready_out, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_parity_err", parity_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame 0x02, latency and done position
    applyStimulus(8'h02, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("latency_tx_low", tx, 0);
    checkOutput("latency_busy", busy, 1);
    checkOutput("latency_not_ready", ready_out, 0);
    waitDone(n);
    checkOutput("done_cycle_0x02", n + 1, 45);
    checkOutput("done_cycle_ready", ready_out, 1);
    @(negedge clk);

    // Held valid, inputs change mid-frame
    s0 = startTimes.size();
    applyStimulus(8'h03, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    data_in   = 8'hFF;
    parity_in = 1'b0;
    waitDone(n);
    checkOutput("done_cycle_0x03", n + 10, 45);
    valid_in = 1'b0;
    @(negedge clk);
    checkOutput("single_accept_busy", busy, 0);
    checkOutput("single_accept_starts", startTimes.size() - s0, 1);

    // Back-to-back frames
    s0 = startTimes.size();
    d0 = doneCount;
    applyStimulus(8'hA5, 1'b1, 1'b1);
    data_in   = 8'h3C;
    parity_in = 1'b1;
    expQ.push_back(frameOf(8'h3C, 1'b1));
    waitDone(n);
    checkOutput("b2b_first_done", n, 45);
    waitDone(n);
    checkOutput("b2b_second_done", n, 45);
    valid_in = 1'b0;
    @(negedge clk);
    checkOutput("b2b_idle_after", busy, 0);
    checkOutput("b2b_starts", startTimes.size() - s0, 2);
    if (startTimes.size() - s0 == 2)
      checkOutput("b2b_period", startTimes[s0 + 1] - startTimes[s0], 45);
    checkOutput("b2b_done_count", doneCount - d0, 2);

    // Reset during data bit 4 of 0xF0
    applyStimulus(8'hF0, 1'b1, 1'b0);
    repeat (22) @(negedge clk);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midreset_tx", tx, 1);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_ready", ready_out, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h01, 1'b0, 1'b0);
    waitDone(n);
    checkOutput("after_reset_done", n, 45);
    @(negedge clk);

`ifdef ODD_PARITY_CHECK_EN
    applyStimulus(8'h02, 1'b1, 1'b0);
    checkOutput("perr_set", parity_err, 1);
    waitDone(n);
    checkOutput("perr_hold", parity_err, 1);
    @(negedge clk);
    applyStimulus(8'h03, 1'b1, 1'b0);
    checkOutput("perr_clear", parity_err, 0);
    waitDone(n);
    checkOutput("perr_frame_done", n, 45);
`else
    applyStimulus(8'h02, 1'b1, 1'b0);
    checkOutput("perr_tied_low", parity_err, 0);
    waitDone(n);
    checkOutput("perr_frame_done", n, 45);
    checkOutput("perr_still_low", parity_err, 0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("exp_queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
